// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- RV32 memory-access pipeline stage.
//
// Takes one load or store at a time from execute, drives the data-memory
// request/acknowledge bus with a word address, byte enables and
// lane-replicated store data, and returns lane-aligned load data together
// with the destination register and funct3 for the writeback extension stage.
// A watchdog aborts any request that is never acknowledged.
//
// Parameters
//   ACK_TIMEOUT  cycles mem_req may stay high without mem_ack (>= 1)
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   ex_valid/ex_ready execute handshake (see below)
//   ex_load/ex_store  operation kind (mutually exclusive)
//   ex_f3, ex_rd      funct3 and destination register
//   ex_addr, ex_wdata effective byte address, rs2 store data
//   mem_req/mem_ack   memory handshake; mem_rdata valid with mem_ack
//   mem_we, mem_addr, mem_be, mem_wdata  registered request attributes
//   d_out             load word shifted down by the byte offset
//   alu_rd, f3_out    registered rd / funct3 of the last accepted access
//   d_r_en, d_w_en    one-cycle load / store completion pulses
//   mis_err           one-cycle pulse: misaligned access or illegal funct3
//   bus_err           one-cycle pulse: watchdog abort
//
// Handshake: an operation transfers on a rising edge where
// ex_valid & ex_ready & (ex_load | ex_store). ex_ready is high only in IDLE
// and out of reset; execute must hold its operation stable until it
// transfers. On the memory side mem_req is held until the edge on which
// mem_ack is sampled high (that edge completes the access) or the watchdog
// fires; mem_ack outside WAIT is ignored.
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_f3,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] d_out,
  output logic [4:0]  alu_rd,
  output logic [2:0]  f3_out,
  output logic        d_r_en,
  output logic        d_w_en,
  output logic        mis_err,
  output logic        bus_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // Counter only needs to reach ACK_TIMEOUT-1; one spare bit is harmless.
  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(ACK_TIMEOUT - 1);

  logic [0:0]    state;
  logic [CW-1:0] wd_cnt;
  logic [1:0]    offset;

  // Decode of the operation currently presented by execute.
  logic [1:0]  size;
  logic        f3_ok;
  logic        misaligned;
  logic        accept;
  logic        reject;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic        expire;

  assign ex_ready = rst & (state == IDLE);
  assign accept   = ex_valid & ex_ready & (ex_load | ex_store);
  assign size     = ex_f3[1:0];

  always_comb begin
    f3_ok = 1'b0;
    if (ex_load) begin
      case (ex_f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end else begin
      // Stores have no unsigned variants.
      f3_ok = ~ex_f3[2] & (size != 2'b11);
    end
  end

  always_comb begin
    misaligned = 1'b0;
    if (size == 2'b01 && ex_addr[0])
      misaligned = 1'b1;
    if (size == 2'b10 && ex_addr[1:0] != 2'b00)
      misaligned = 1'b1;
  end

  assign reject = ~f3_ok | misaligned;

  // Byte lanes and replicated store data; loads reuse the same enables.
  always_comb begin
    acc_be    = 4'b1111;
    acc_wdata = ex_wdata;
    case (size)
      2'b00: begin
        acc_be    = 4'b0001 << ex_addr[1:0];
        acc_wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        acc_be    = 4'b0011 << {ex_addr[1], 1'b0};
        acc_wdata = {2{ex_wdata[15:0]}};
      end
      default: begin
        acc_be    = 4'b1111;
        acc_wdata = ex_wdata;
      end
    endcase
  end

  // Last WAIT cycle the watchdog allows; an ack in this cycle still wins.
  assign expire = (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      wd_cnt    <= '0;
      offset    <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
      d_out     <= 32'h0;
      alu_rd    <= 5'd0;
      f3_out    <= 3'd0;
      d_r_en    <= 1'b0;
      d_w_en    <= 1'b0;
      mis_err   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      // Pulse outputs default low so each event lasts exactly one cycle.
      d_r_en  <= 1'b0;
      d_w_en  <= 1'b0;
      mis_err <= 1'b0;
      bus_err <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (reject) begin
              // Nothing reaches memory; the stage stays ready.
              mis_err <= 1'b1;
            end else begin
              state     <= WAIT;
              wd_cnt    <= '0;
              mem_req   <= 1'b1;
              mem_we    <= ex_store;
              mem_addr  <= {ex_addr[31:2], 2'b00};
              mem_be    <= acc_be;
              mem_wdata <= acc_wdata;
              offset    <= ex_addr[1:0];
              alu_rd    <= ex_rd;
              f3_out    <= ex_f3;
            end
          end
        end

        WAIT: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (mem_we) begin
              d_w_en <= 1'b1;
            end else begin
              d_out  <= mem_rdata >> {offset, 3'b000};
              d_r_en <= 1'b1;
            end
          end else if (expire) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage (ACK_TIMEOUT = 4).
// Directed vector table, hand sequences for reset/idle corner cases, and
// randomized operations checked against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam int T = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_load, ex_store;
  logic [2:0]  ex_f3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_addr, ex_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, d_out;
  logic [3:0]  mem_be;
  logic [4:0]  alu_rd;
  logic [2:0]  f3_out;
  logic        d_r_en, d_w_en, mis_err, bus_err;

  always #5 clk = ~clk;

  mem_stage #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_load(ex_load), .ex_store(ex_store),
    .ex_f3(ex_f3), .ex_rd(ex_rd), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .d_out(d_out), .alu_rd(alu_rd), .f3_out(f3_out),
    .d_r_en(d_r_en), .d_w_en(d_w_en), .mis_err(mis_err), .bus_err(bus_err)
  );

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    logic        load;
    logic        store;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;   // cycles after accept before ack; >= T means none
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] dout;
    logic        mis;
    logic        bus;
  } vec_t;

  logic [31:0] exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] held_dout;
  logic [4:0]  held_rd;
  logic [2:0]  held_f3;
  vec_t        tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [31:0] addr,
                              input logic [31:0] wd, input int dly, input logic [31:0] rdat,
                              input logic [3:0] be, input logic [31:0] mwd,
                              input logic [31:0] dout, input logic mis, input logic bus);
    vec_t v;
    v.load = ld; v.store = st; v.f3 = f3; v.rd = rd; v.addr = addr; v.wdata = wd;
    v.delay = dly; v.rdata = rdat; v.be = be; v.mwdata = mwd; v.dout = dout;
    v.mis = mis; v.bus = bus;
    return v;
  endfunction

  // Reference model: access size in bytes, lane coverage and byte
  // replication computed per lane from the architectural rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   nbytes = 1 << v.f3[1:0];
    int   lane0  = int'(v.addr % 4);
    logic legal;
    if (v.load) legal = (v.f3 == 0 || v.f3 == 1 || v.f3 == 2 || v.f3 == 4 || v.f3 == 5);
    else        legal = (v.f3 <= 2);
    r.mis = !legal || ((v.addr % nbytes) != 0);
    for (int i = 0; i < 4; i++) begin
      r.be[i] = (i >= lane0) && (i < lane0 + nbytes);
      r.mwdata[8*i +: 8] = v.wdata[8*(i % nbytes) +: 8];
    end
    r.dout = v.rdata >> (8 * lane0);
    r.bus  = (v.delay >= T);
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, ex_ready, 0);
    chk({tag, "_req"},   mem_req,  0);
    chk({tag, "_we"},    mem_we,   0);
    chk({tag, "_addr"},  mem_addr, 0);
    chk({tag, "_be"},    mem_be,   0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_dout"},  d_out,    0);
    chk({tag, "_rd"},    alu_rd,   0);
    chk({tag, "_f3"},    f3_out,   0);
    chk({tag, "_pulses"}, {d_r_en, d_w_en, mis_err, bus_err}, 0);
  endtask

  // Drive one operation from IDLE through completion/abort and check every
  // cycle of it against the expectations carried in v.
  task automatic do_op(input vec_t v);
    int last;
    chk("ready_pre", ex_ready, 1);
    ex_valid = 1'b1; ex_load = v.load; ex_store = v.store; ex_f3 = v.f3;
    ex_rd = v.rd; ex_addr = v.addr; ex_wdata = v.wdata;
    step();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    if (v.mis) begin
      chk("mis_pulse", mis_err, 1);
      chk("mis_no_req", mem_req, 0);
      chk("mis_ready", ex_ready, 1);
      chk("mis_rd_held", alu_rd, held_rd);
      step();
      chk("mis_width", {mis_err, mem_req, d_r_en, d_w_en, bus_err}, 0);
      return;
    end
    held_rd = v.rd;
    held_f3 = v.f3;
    chk("req_set", mem_req, 1);
    chk("we", mem_we, v.store);
    chk("addr", mem_addr, v.addr & ~32'h3);
    chk("be", mem_be, v.be);
    chk("wdata", mem_wdata, v.mwdata);
    chk("alu_rd", alu_rd, v.rd);
    chk("f3_out", f3_out, v.f3);
    chk("busy", ex_ready, 0);
    if (v.load && !v.bus) exp_q.push_back(v.dout);
    last = v.bus ? T - 1 : v.delay;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        chk("req_hold", mem_req, 1);
        chk("busy_wait", ex_ready, 0);
        chk("no_early_pulse", {d_r_en, d_w_en, bus_err}, 0);
      end
      mem_ack   = (!v.bus && c == v.delay);
      mem_rdata = mem_ack ? v.rdata : $urandom;
      step();
    end
    mem_ack = 1'b0;
    chk("req_clear", mem_req, 0);
    chk("ready_post", ex_ready, 1);
    chk("d_r_en", d_r_en, v.load && !v.bus);
    chk("d_w_en", d_w_en, v.store && !v.bus);
    chk("bus_err", bus_err, v.bus);
    if (d_r_en) begin
      if (exp_q.size() == 0) chk("sb_unexpected_load", 1, 0);
      else                   chk("sb_dout", d_out, exp_q.pop_front());
    end
    if (v.load && !v.bus) held_dout = v.dout;
    chk("dout_held", d_out, held_dout);
    step();
    chk("pulse_width", {d_r_en, d_w_en, mis_err, bus_err}, 0);
    chk("dout_hold2", d_out, held_dout);
    chk("rd_hold", alu_rd, held_rd);
  endtask

  // ---------------- test ----------------
  initial begin
    //           ld st f3      rd     addr          wdata         dly rdata         be       mwdata        dout          mis bus
    tbl[0]  = mk(1, 0, 3'b010, 5'd5,  32'h0000_0104, 32'h0,        0, 32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0);
    tbl[1]  = mk(1, 0, 3'b000, 5'd7,  32'h0000_0203, 32'h0,        1, 32'h80FFFFFF, 4'b1000, 32'h0,        32'h00000080, 0, 0);
    tbl[2]  = mk(0, 1, 3'b001, 5'd3,  32'h0000_0302, 32'h1234ABCD, 3, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0,        0, 0);
    tbl[3]  = mk(1, 0, 3'b010, 5'd9,  32'h0000_0101, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);
    tbl[4]  = mk(1, 0, 3'b011, 5'd9,  32'h0000_0100, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);
    tbl[5]  = mk(0, 1, 3'b010, 5'd2,  32'h0000_0010, 32'hCAFEF00D, 4, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0,        0, 1);
    tbl[6]  = mk(1, 0, 3'b101, 5'd11, 32'h0000_0402, 32'h0,        0, 32'h89AB0123, 4'b1100, 32'h0,        32'h000089AB, 0, 0);
    tbl[7]  = mk(0, 1, 3'b000, 5'd12, 32'h0000_0001, 32'h000000A5, 0, 32'h0,        4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0);
    tbl[8]  = mk(0, 1, 3'b100, 5'd13, 32'h0000_0000, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);
    tbl[9]  = mk(1, 0, 3'b001, 5'd14, 32'h0000_0003, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0);
    tbl[10] = mk(1, 0, 3'b100, 5'd15, 32'h0000_0502, 32'h0,        3, 32'h11223344, 4'b0100, 32'h0,        32'h00001122, 0, 0);

    rst = 1'b0; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_f3 = '0;
    ex_rd = '0; ex_addr = '0; ex_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    held_dout = '0; held_rd = '0; held_f3 = '0;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b1;
    step();
    chk("ready_after_reset", ex_ready, 1);

    // Directed table.
    foreach (tbl[i]) do_op(tbl[i]);

    // ex_valid with neither load nor store is ignored.
    ex_valid = 1'b1; ex_addr = 32'h0000_0101; ex_f3 = 3'b010;
    step();
    ex_valid = 1'b0;
    chk("nop_no_req", mem_req, 0);
    chk("nop_no_mis", mis_err, 0);
    chk("nop_ready", ex_ready, 1);

    // Ack while idle is ignored.
    mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_pulses", {d_r_en, d_w_en, bus_err, mis_err}, 0);
    chk("idle_ack_dout", d_out, held_dout);
    chk("idle_ack_req", mem_req, 0);

    // Reset while waiting for an ack.
    ex_valid = 1'b1; ex_load = 1'b1; ex_f3 = 3'b010; ex_rd = 5'd9; ex_addr = 32'h40;
    step();
    ex_valid = 1'b0; ex_load = 1'b0;
    chk("rw_req", mem_req, 1);
    step();
    rst = 1'b0;
    step();
    check_all_zero("rw_reset");
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step();
    check_all_zero("rw_ack_in_reset");
    rst = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rw_ready", ex_ready, 1);
    chk("rw_no_req", mem_req, 0);
    chk("rw_no_pulse", {d_r_en, d_w_en, bus_err, mis_err}, 0);
    chk("rw_dout", d_out, 0);
    held_dout = '0; held_rd = '0; held_f3 = '0;
    exp_q.delete();
    do_op(tbl[0]);

    // Randomized operations against the model.
    for (int n = 0; n < 200; n++) begin
      vec_t v;
      v.load  = 1'($urandom_range(0, 1));
      v.store = !v.load;
      v.f3    = 3'($urandom_range(0, 7));
      v.rd    = 5'($urandom);
      v.addr  = $urandom;
      if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.delay = $urandom_range(0, T + 1);
      do_op(model(v));
    end

    if (exp_q.size() != 0) chk("sb_leftover", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
